// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer.
//   ctr_t       : widest supported prediction counter (1..4 bits)
//   log2        : ceiling log2 for elaboration-time sizing
//   ctr_inc/dec : saturating counter steps for a counter of width w
//   weak_taken  : counter value given to a freshly allocated entry
package btb_pkg;

  localparam int CTR_MAX_W = 4;

  typedef logic [CTR_MAX_W-1:0] ctr_t;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic ctr_t ctr_max(input int w);
    return ctr_t'((1 << w) - 1);
  endfunction

  function automatic ctr_t ctr_inc(input ctr_t c, input int w);
    return (c >= ctr_max(w)) ? ctr_max(w) : c + ctr_t'(1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == '0) ? c : c - ctr_t'(1);
  endfunction

  // MSB-only pattern: lowest value that still predicts taken.
  function automatic ctr_t weak_taken(input int w);
    return ctr_t'(1 << (w - 1));
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup and EX-side update bundle of the branch target buffer.
//   master : fetch/EX side, drives STALL, PC and the UPD_* fields
//   slave  : the BTB, returns PRD_HIT / PRD_TAKEN / PRD_ADDR
interface btb_assoc_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  STALL;
  logic [ADDR_WIDTH-1:0] PC;
  logic                  PRD_HIT;
  logic                  PRD_TAKEN;
  logic [ADDR_WIDTH-1:0] PRD_ADDR;
  logic                  UPD_VALID;
  logic [ADDR_WIDTH-1:0] UPD_PC;
  logic                  UPD_TAKEN;
  logic [ADDR_WIDTH-1:0] UPD_TARGET;
  logic                  UPD_FLUSH;

  modport master (
    output STALL, PC, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET, UPD_FLUSH,
    input  PRD_HIT, PRD_TAKEN, PRD_ADDR
  );

  modport slave (
    input  STALL, PC, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET, UPD_FLUSH,
    output PRD_HIT, PRD_TAKEN, PRD_ADDR
  );
endinterface

// File: rtl/btb_way.sv
// One way of the BTB: per-set valid, tag, target and counter storage.
//   lk_*  : combinational read port for the fetch lookup
//   up_*  : combinational read port for the update stage; the write
//           (wr_en) targets the same set/tag and marks the entry valid
// Only the valid bits are reset; the data arrays are plain storage.
module btb_way
  import btb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 256,
  parameter int CTR_WIDTH  = 2,
  localparam int IDX       = log2(SETS),
  localparam int TAG_W     = ADDR_WIDTH - IDX - 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [IDX-1:0]        lk_idx,
  input  logic [TAG_W-1:0]      lk_tag,
  output logic                  lk_hit,
  output logic [CTR_WIDTH-1:0]  lk_ctr,
  output logic [ADDR_WIDTH-1:0] lk_tgt,
  input  logic [IDX-1:0]        up_idx,
  input  logic [TAG_W-1:0]      up_tag,
  output logic                  up_vld,
  output logic                  up_hit,
  output logic [CTR_WIDTH-1:0]  up_ctr,
  output logic [ADDR_WIDTH-1:0] up_tgt,
  input  logic                  wr_en,
  input  logic [CTR_WIDTH-1:0]  wr_ctr,
  input  logic [ADDR_WIDTH-1:0] wr_tgt
);

  logic [SETS-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]      tag_mem [SETS];
  logic [ADDR_WIDTH-1:0] tgt_mem [SETS];
  logic [CTR_WIDTH-1:0]  ctr_mem [SETS];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[up_idx] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_mem[up_idx] <= up_tag;
      tgt_mem[up_idx] <= wr_tgt;
      ctr_mem[up_idx] <= wr_ctr;
    end
  end

  assign lk_hit = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign lk_ctr = ctr_mem[lk_idx];
  assign lk_tgt = tgt_mem[lk_idx];

  assign up_vld = valid_q[up_idx];
  assign up_hit = valid_q[up_idx] && (tag_mem[up_idx] == up_tag);
  assign up_ctr = ctr_mem[up_idx];
  assign up_tgt = tgt_mem[up_idx];

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : btb_assoc_if slave; combinational lookup of bus.PC returns
//              PRD_HIT/PRD_TAKEN/PRD_ADDR, resolved branches on UPD_*
//              pass through register stage U1 and are written in U2.
// Misses that resolve taken allocate the lowest invalid way, otherwise
// the set's round-robin victim.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 256,
  parameter int WAYS       = 2,
  parameter int CTR_WIDTH  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  btb_assoc_if.slave  bus
);

  localparam int IDX   = log2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;
  localparam int PW    = (WAYS > 1) ? log2(WAYS) : 1;

  // ---- U1: register the resolved branch ----
  logic                  u1_vld_q, u1_vld_d;
  logic [ADDR_WIDTH-1:2] u1_pc_q, u1_pc_d;
  logic                  u1_taken_q, u1_taken_d;
  logic [ADDR_WIDTH-1:0] u1_tgt_q, u1_tgt_d;

  always_comb begin
    u1_vld_d   = u1_vld_q;
    u1_pc_d    = u1_pc_q;
    u1_taken_d = u1_taken_q;
    u1_tgt_d   = u1_tgt_q;
    if (!bus.STALL) begin
      u1_vld_d   = bus.UPD_VALID & ~bus.UPD_FLUSH;
      u1_pc_d    = bus.UPD_PC[ADDR_WIDTH-1:2];
      u1_taken_d = bus.UPD_TAKEN;
      u1_tgt_d   = bus.UPD_TARGET;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      u1_vld_q   <= 1'b0;
      u1_pc_q    <= '0;
      u1_taken_q <= 1'b0;
      u1_tgt_q   <= '0;
    end else begin
      u1_vld_q   <= u1_vld_d;
      u1_pc_q    <= u1_pc_d;
      u1_taken_q <= u1_taken_d;
      u1_tgt_q   <= u1_tgt_d;
    end
  end

  // ---- U2: way array, lookup and write decision ----
  logic [IDX-1:0]        lk_idx, up_idx;
  logic [TAG_W-1:0]      lk_tag, up_tag;
  logic [WAYS-1:0]       lk_hit, up_hit, up_vld, way_we;
  logic [CTR_WIDTH-1:0]  lk_ctr [WAYS];
  logic [CTR_WIDTH-1:0]  up_ctr [WAYS];
  logic [ADDR_WIDTH-1:0] lk_tgt [WAYS];
  logic [ADDR_WIDTH-1:0] up_tgt [WAYS];
  logic [CTR_WIDTH-1:0]  wr_ctr;
  logic [ADDR_WIDTH-1:0] wr_tgt;

  assign lk_idx = bus.PC[IDX+1:2];
  assign lk_tag = bus.PC[ADDR_WIDTH-1:IDX+2];
  assign up_idx = u1_pc_q[IDX+1:2];
  assign up_tag = u1_pc_q[ADDR_WIDTH-1:IDX+2];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    btb_way #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .SETS       (SETS),
      .CTR_WIDTH  (CTR_WIDTH)
    ) u_way (
      .CLK    (CLK),
      .RST    (RST),
      .lk_idx (lk_idx),
      .lk_tag (lk_tag),
      .lk_hit (lk_hit[g]),
      .lk_ctr (lk_ctr[g]),
      .lk_tgt (lk_tgt[g]),
      .up_idx (up_idx),
      .up_tag (up_tag),
      .up_vld (up_vld[g]),
      .up_hit (up_hit[g]),
      .up_ctr (up_ctr[g]),
      .up_tgt (up_tgt[g]),
      .wr_en  (way_we[g]),
      .wr_ctr (wr_ctr),
      .wr_tgt (wr_tgt)
    );
  end

  // Fetch lookup: scanning downwards lets the lowest matching way win.
  logic                  prd_hit, prd_taken;
  logic [CTR_WIDTH-1:0]  prd_ctr;
  logic [ADDR_WIDTH-1:0] prd_tgt;

  always_comb begin
    prd_hit = 1'b0;
    prd_ctr = '0;
    prd_tgt = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_hit[w]) begin
        prd_hit = 1'b1;
        prd_ctr = lk_ctr[w];
        prd_tgt = lk_tgt[w];
      end
    end
  end

  assign prd_taken     = prd_hit & prd_ctr[CTR_WIDTH-1];
  assign bus.PRD_HIT   = prd_hit;
  assign bus.PRD_TAKEN = prd_taken;
  assign bus.PRD_ADDR  = prd_taken ? prd_tgt : bus.PC + ADDR_WIDTH'(4);

  // Update-side hit and victim search.
  logic                  u_hit, inv_found;
  logic [PW-1:0]         u_way, inv_way;
  logic [CTR_WIDTH-1:0]  u_ctr;
  logic [ADDR_WIDTH-1:0] u_tgt;

  always_comb begin
    u_hit     = 1'b0;
    u_way     = '0;
    u_ctr     = '0;
    u_tgt     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (up_hit[w]) begin
        u_hit = 1'b1;
        u_way = PW'(w);
        u_ctr = up_ctr[w];
        u_tgt = up_tgt[w];
      end
      if (!up_vld[w]) begin
        inv_found = 1'b1;
        inv_way   = PW'(w);
      end
    end
  end

  // Round-robin pointer per set; advances only on eviction of a valid way.
  logic [PW-1:0] rr_q [SETS];
  logic [PW-1:0] rr_cur, rr_d;
  logic          rr_we;
  logic          u2_fire;

  assign rr_cur  = rr_q[up_idx];
  // RST drops an update captured before it, even if STALL is low.
  assign u2_fire = u1_vld_q & ~bus.STALL & ~RST;

  always_comb begin
    way_we = '0;
    wr_ctr = '0;
    wr_tgt = u1_tgt_q;
    rr_we  = 1'b0;
    rr_d   = rr_cur;
    if (u2_fire) begin
      if (u_hit) begin
        way_we[u_way] = 1'b1;
        wr_ctr = u1_taken_q ? CTR_WIDTH'(ctr_inc(ctr_t'(u_ctr), CTR_WIDTH))
                            : CTR_WIDTH'(ctr_dec(ctr_t'(u_ctr)));
        wr_tgt = u1_taken_q ? u1_tgt_q : u_tgt;
      end else if (u1_taken_q) begin
        wr_ctr = CTR_WIDTH'(weak_taken(CTR_WIDTH));
        if (inv_found) begin
          way_we[inv_way] = 1'b1;
        end else begin
          way_we[rr_cur] = 1'b1;
          rr_we = 1'b1;
          rr_d  = (WAYS == 1) ? '0 : rr_cur + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (rr_we) begin
      rr_q[up_idx] <= rr_d;
    end
  end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer with configurable counter width; successor to the direct-mapped single-way predictor in the fetch stage. Each fetch cycle it looks up the fetch PC and supplies a predicted next PC. Resolved branches from EX arrive one per cycle through a registered update port and train per-entry saturating counters. Misses allocate a way using invalid-first, then per-set round-robin replacement.

## Interface
- ADDR_WIDTH, 32, PC/target width
- SETS, 256, sets; power of two ≥ 2; IDX = log2(SETS)
- WAYS, 2, ways per set; power of two, 1..8
- CTR_WIDTH, 2, saturating counter width, 1..4
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- STALL  in  1  freezes the update pipeline (cache not ready)
- PC  in  ADDR_WIDTH  fetch PC to look up
- PRD_HIT  out  1  valid tag match in PC's set
- PRD_TAKEN  out  1  hit and counter MSB set
- PRD_ADDR  out  ADDR_WIDTH  predicted next PC
- UPD_VALID  in  1  resolved branch present
- UPD_PC  in  ADDR_WIDTH  PC of resolved branch
- UPD_TAKEN  in  1  actual direction
- UPD_TARGET  in  ADDR_WIDTH  actual target
- UPD_FLUSH  in  1  squash this update

## Operation
- Index = PC[IDX+1:2]; tag = PC[ADDR_WIDTH-1:IDX+2]; PC[1:0] ignored.
- Lookup is combinational over all ways of the set. Hit requires valid and tag equal. If more than one way matches, the lowest way index wins; allocation rules prevent duplicates.
- PRD_ADDR = PRD_TAKEN ? target : PC+4, modulo 2^ADDR_WIDTH.
- Stage U1 registers: when !STALL, capture UPD_VALID & !UPD_FLUSH, UPD_PC, UPD_TAKEN and UPD_TARGET.
- Stage U2 write: when the U1 valid bit is set and !STALL, look up the U1 PC and apply the rules below.
- Hit, taken: counter +1, saturating at 2^CTR_WIDTH−1; target ← UPD_TARGET.
- Hit, not taken: counter −1, saturating at 0; target unchanged.
- Miss, taken: allocate. Victim is the lowest invalid way; if none, the set's round-robin pointer. Write tag, target and valid=1. Counter ← 2^(CTR_WIDTH−1) (weakly taken). The pointer advances mod WAYS only when a valid way was evicted.
- Miss, not taken: no state change.
- RST clears all valid bits, all round-robin pointers and the U1 registers. Tag, target and counter arrays are not reset. RST has priority over STALL.
- Outputs after reset: PRD_HIT=0, PRD_TAKEN=0, PRD_ADDR=PC+4.
- No bypass. A lookup in the cycle of a U2 write to the same set returns the pre-write contents.
- CTR_WIDTH=1: the counter is a last-direction bit; taken and not-taken set and clear it.

## Timing
- Lookup latency: 0 cycles (combinational from PC).
- An update presented at edge n is captured at edge n. The array is written at edge n+1. The result is visible to lookup after edge n+1.
- STALL high holds U1 and blocks the U2 write. A pending update is written on the first unstalled edge, exactly once.
- Back-to-back updates to the same entry are legal every cycle. Each sees the result of the previous one.
- Reset mid-stream drops any captured update.

## Structure
- btb_pkg: ctr_inc/ctr_dec saturating functions, weak-taken constant, log2 function.
- One sub-module, btb_way: one way's tag, target, counter and valid storage with read and write ports, instantiated WAYS times by generate. Replacement pointers and the update pipeline live in btb_assoc.

## Test plan
- Reset, then PC=0x100 → PRD_HIT=0, PRD_ADDR=0x104.
- Taken update PC=0x100, target 0x400, then PC=0x100 two cycles later → hit; counter=2; PRD_TAKEN=1; PRD_ADDR=0x400.
- Two not-taken updates for 0x100, then one taken → counter 2→1→0→1; PRD_TAKEN=0, PRD_ADDR=0x104. A further taken update gives 2 and PRD_TAKEN=1.
- SETS=256, WAYS=2: taken updates for 0x100, 0x500 and 0x900 (same set) → ways filled 0 then 1; 0x900 evicts way 0 (0x100 now misses); a fourth conflicting branch evicts way 1.
- Update with UPD_FLUSH=1 → no state change. Update held under STALL for 3 cycles → written once on the first unstalled edge.
- Saturation at CTR_WIDTH=3: eight taken updates → counter=7. Target change on a hit → PRD_ADDR follows the new target.
